// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous RAM between two requesters; port 0 has fixed priority, port 1 has a starvation guard
module mem_arbiter #(
   parameter int ADDR_W     = 9,
   parameter int DATA_W     = 16,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        m0_cmd,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ready,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic [1:0]        m1_cmd,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ready,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   output logic              ram_write,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              cmd_err
);
   localparam int CW = $clog2(STARVE_MAX + 1);
   localparam logic [1:0] CMD_WRITE = 2'b10;
   typedef enum logic {PRI0, PRI1} state_t;
   state_t state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic a0, a1, g0, g1;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] din_q;
   logic [1:0] rd_owner;
   // grant decision, RAM drive and next arbitration state; grants are masked while reset is asserted
   always_comb begin
      a0 = m0_cmd[0] ^ m0_cmd[1];
      a1 = m1_cmd[0] ^ m1_cmd[1];
      g1 = reset & a1 & (state == PRI1 | ~a0);
      g0 = reset & a0 & ~g1;
      state_nx = PRI0;
      cnt_nx = '0;
      if (state == PRI0 && g0 && a1) begin
         if (cnt == CW'(STARVE_MAX - 1)) state_nx = PRI1;
         else cnt_nx = cnt + 1'b1;
      end
      m0_ready = g0;
      m1_ready = g1;
      ram_write = g0 ? m0_cmd == CMD_WRITE : g1 & (m1_cmd == CMD_WRITE);
      ram_addr = g0 ? m0_addr : g1 ? m1_addr : addr_q;
      ram_din = g0 ? m0_wdata : g1 ? m1_wdata : din_q;
      m0_rvalid = rd_owner == 2'b10;
      m1_rvalid = rd_owner == 2'b11;
      m0_rdata = ram_dout;
      m1_rdata = ram_dout;
   end
   // arbitration state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= PRI0;
         cnt <= '0;
      end else begin
         state <= state_nx;
         cnt <= cnt_nx;
      end
   end
   // held RAM address/data, read owner tracking for the 1-cycle read return, sticky illegal-command flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q <= '0;
         din_q <= '0;
         rd_owner <= 2'b00;
         cmd_err <= 1'b0;
      end else begin
         if (g0 | g1) begin
            addr_q <= ram_addr;
            din_q <= ram_din;
         end
         rd_owner <= {(g0 | g1) & ~ram_write, g1};
         cmd_err <= cmd_err | (&m0_cmd) | (&m1_cmd);
      end
   end
endmodule
